// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential restoring divider
package div_pkg;

    localparam int DIV_W     = 8;
    localparam int DIV_CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   pr,
    input  logic         next_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   pr_next,
    output logic         q_bit
);

    logic [W:0] t;
    logic       unused_pr_msb;

    // A valid partial remainder is always below the divisor, so its top bit is zero.
    assign unused_pr_msb = pr[W];
    assign t = {pr[W-1:0], next_bit};

    always_comb begin
        q_bit   = (t >= {1'b0, divisor});
        pr_next = q_bit ? (t - {1'b0, divisor}) : t;
    end

endmodule

// File: rtl/seq_div_restoring.sv
// rtl/seq_div_restoring.sv - multi-cycle 2W/W restoring divider with optional early termination
module seq_div_restoring
    import div_pkg::*;
#(
    parameter int W           = DIV_W,
    parameter int APPROX_DROP = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

    localparam int N  = W - APPROX_DROP;
    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e     state, state_nxt;
    logic [W:0]     pr;
    logic [W-1:0]   lo;
    logic [W-1:0]   dvs;
    logic [W-2:0]   q_work;
    logic [CW-1:0]  cnt;

    logic [W:0]     pr_nxt;
    logic           q_bit;
    logic [W-1:0]   q_shift;
    logic [W-1:0]   q_fin;
    logic           is_zero;
    logic           is_ovf;

    div_step #(.W(W)) u_step (
        .pr       (pr),
        .next_bit (lo[W-1]),
        .divisor  (dvs),
        .pr_next  (pr_nxt),
        .q_bit    (q_bit)
    );

    assign is_zero = (divisor == '0);
    assign is_ovf  = (dividend[2*W-1:W] >= divisor);
    assign q_shift = {q_work, q_bit};
    // Early termination leaves the N computed bits at the top, dropped bits read as zero.
    assign q_fin   = q_shift << APPROX_DROP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (is_zero || is_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr        <= '0;
            lo        <= '0;
            dvs       <= '0;
            q_work    <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs    <= divisor;
                        lo     <= dividend[W-1:0];
                        pr     <= {1'b0, dividend[2*W-1:W]};
                        q_work <= '0;
                        cnt    <= '0;
                        if (is_zero) begin
                            div_zero  <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[W-1:0];
                        end else if (is_ovf) begin
                            ovf       <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                        end
                    end
                end
                RUN: begin
                    pr     <= pr_nxt;
                    lo     <= {lo[W-2:0], 1'b0};
                    q_work <= q_shift[W-2:0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient  <= q_fin;
                        remainder <= (APPROX_DROP > 0) ? '0 : pr_nxt[W-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_restoring.sv
// tb/tb_seq_div_restoring.sv - scoreboard bench for exact and approximate divider instances
module tb_seq_div_restoring;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready, div_zero, ovf;
    logic [7:0]  quotient  [2];
    logic [7:0]  remainder [2];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_div_restoring #(.W(8), .APPROX_DROP(0)) dut_exact (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .quotient(quotient[0]), .remainder(remainder[0]),
        .div_zero(div_zero[0]), .ovf(ovf[0])
    );

    seq_div_restoring #(.W(8), .APPROX_DROP(2)) dut_approx (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .quotient(quotient[1]), .remainder(remainder[1]),
        .div_zero(div_zero[1]), .ovf(ovf[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input int sel, input logic [15:0] dvd, input logic [7:0] dvs);
        @(negedge clk);
        dividend      = dvd;
        divisor       = dvs;
        in_valid[sel] = 1'b1;
        check_val("in_ready_idle", 32'(in_ready[sel]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
    endtask

    // Returns the number of rising edges, accept edge included, until out_valid is seen.
    task automatic wait_result(input int sel, output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid[sel] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input int sel, input string tag);
        int   lat;
        exp_t e;
        wait_result(sel, lat);
        check_val({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val({tag, "_latency"},   32'(lat),            32'(e.lat));
            check_val({tag, "_quotient"},  32'(quotient[sel]),  32'(e.q));
            check_val({tag, "_remainder"}, 32'(remainder[sel]), 32'(e.r));
            check_val({tag, "_div_zero"},  32'(div_zero[sel]),  32'(e.dz));
            check_val({tag, "_ovf"},       32'(ovf[sel]),       32'(e.ov));
        end
    endtask

    task automatic retire(input int sel, input string tag);
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[sel] = 1'b0;
        @(negedge clk);
        check_val({tag, "_in_ready_after"},  32'(in_ready[sel]),  32'd1);
        check_val({tag, "_out_valid_after"}, 32'(out_valid[sel]), 32'd0);
        check_val({tag, "_flags_cleared"},   32'({div_zero[sel], ovf[sel]}), 32'd0);
    endtask

    task automatic do_op(input int sel, input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] q, input logic [7:0] r, input logic dz, input logic ov, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat;
        sb.push_back(e);
        start_op(sel, dvd, dvs);
        check_result(sel, tag);
        retire(sel, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_val("rst_in_ready",  32'(in_ready[s]),  32'd1);
            check_val("rst_out_valid", 32'(out_valid[s]), 32'd0);
            check_val("rst_outputs",   {16'(quotient[s]), 8'(remainder[s]), 6'd0, div_zero[s], ovf[s]}, 32'd0);
        end
        rst = 1'b0;

        do_op(0, "basic_200_7", 16'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 9);
        do_op(0, "max_fit",     16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9);
        do_op(0, "ovf_edge",    16'hFF00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
        do_op(0, "div_zero",    16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1);

        for (int i = 0; i < 6; i++) begin
            logic [7:0]  dvs;
            logic [15:0] dvd;
            dvs = 8'($urandom_range(1, 255));
            dvd = {8'($urandom_range(0, int'(dvs) - 1)), 8'($urandom_range(0, 255))};
            do_op(0, "random", dvd, dvs, 8'(dvd / 16'(dvs)), 8'(dvd % 16'(dvs)), 1'b0, 1'b0, 9);
        end

        // Backpressure: the result must hold while a competing request is presented.
        e.q = 8'd28; e.r = 8'd4; e.dz = 1'b0; e.ov = 1'b0; e.lat = 9;
        sb.push_back(e);
        start_op(0, 16'd200, 8'd7);
        check_result(0, "bp");
        dividend    = 16'd100;
        divisor     = 8'd3;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_hold_quotient",  32'(quotient[0]),  32'd28);
            check_val("bp_hold_remainder", 32'(remainder[0]), 32'd4);
            check_val("bp_hold_out_valid", 32'(out_valid[0]), 32'd1);
            check_val("bp_in_ready_low",   32'(in_ready[0]),  32'd0);
        end
        in_valid[0] = 1'b0;
        retire(0, "bp");
        check_val("bp_quotient_kept", 32'(quotient[0]), 32'd28);
        repeat (3) @(negedge clk);
        check_val("bp_no_capture", 32'(out_valid[0]), 32'd0);

        // Reset asserted during the fourth RUN cycle aborts without a result.
        start_op(0, 16'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("abort_in_ready",  32'(in_ready[0]),  32'd1);
        check_val("abort_out_valid", 32'(out_valid[0]), 32'd0);
        check_val("abort_outputs",   {16'(quotient[0]), 8'(remainder[0]), 6'd0, div_zero[0], ovf[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(0, "after_abort", 16'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b0, 9);

        do_op(1, "approx_1000_9", 16'd1000, 8'd9, 8'h6C, 8'h00, 1'b0, 1'b0, 7);
        do_op(1, "approx_ovf",    16'hFF00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1);

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div_restoring.md
Name: seq_div_restoring

Overview:
- Multi-cycle restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and W-bit remainder.
- Inverse-operation companion to the 8x8 approximate multiplier datapath. Used to recover operands from products and to check multiplier error (product / operand versus the other operand).
- Supports an approximate mode that drops low quotient bits through early termination, matching the team's accuracy/latency trade-off style.

Parameters:
- W, 8, operand width; dividend is 2W bits, quotient and remainder are W bits.
- APPROX_DROP, 0, number of low quotient bits not computed (0..W-1). Iteration count N = W - APPROX_DROP.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- dividend  input  2W  unsigned dividend.
- divisor  input  W  unsigned divisor.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  W  unsigned quotient.
- remainder  output  W  unsigned remainder.
- div_zero  output  1  divisor was 0.
- ovf  output  1  quotient does not fit in W bits.

Behaviour:
- Reset, asynchronous, active-high. State goes to IDLE. in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, ovf=0. All internal registers clear.
- States and transitions:
  - IDLE: in_ready=1. When in_valid is high, operands are registered.
    - divisor==0: go to DONE with div_zero=1, quotient=all ones, remainder=dividend[W-1:0].
    - Else if dividend[2W-1:W] >= divisor: go to DONE with ovf=1, quotient=all ones, remainder=0.
    - Else: go to RUN. Partial remainder PR (W+1 bits) = {0, dividend[2W-1:W]}. Iteration counter = 0.
  - RUN: in_ready=0. Each cycle:
    - T = {PR[W-1:0], next dividend bit, MSB first from bit W-1}.
    - If T >= divisor: PR = T - divisor and the quotient bit is 1. Otherwise PR = T and the quotient bit is 0.
    - Quotient shifts left by one bit each cycle.
    - After N iterations, go to DONE.
  - DONE: out_valid=1. Outputs are stable and held while out_ready=0. When out_valid and out_ready are both high, go to IDLE, drop out_valid, and clear the flags. Quotient and remainder keep their last values.
- Latency: exactly N+1 cycles from the accept edge to out_valid for normal division. 1 cycle for div_zero or ovf.
- Throughput: one operation in flight. in_ready is high only in IDLE, so there is no overlap of accept and retire.
- Approximate mode (APPROX_DROP>0):
  - Quotient = computed N MSBs followed by APPROX_DROP zeros.
  - remainder output is forced to 0, so only quotient is meaningful.
  - div_zero and ovf behave as in exact mode.
- Width rules:
  - All arithmetic is unsigned.
  - The compare and subtract are W+1 bits wide, so no carry is lost at divisor values near 2^W-1.
- in_valid while busy is ignored. No capture takes place, and the source must hold its data until in_ready.
- Reset asserted in RUN or DONE aborts the operation immediately. No out_valid is produced for it.

Decomposition:
- Shared package div_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default W;
  - localparam for counter width, clog2(W).
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: PR, next bit, divisor.
  - Outputs: new PR, quotient bit.
  - Reused unchanged if the team later builds an unrolled or pipelined variant.

Test Plan:
- Exact, W=8: dividend=200, divisor=7 -> out_valid 9 cycles after accept; quotient=28, remainder=4, flags 0.
- Boundary: dividend=0xFE01, divisor=0xFF -> quotient=0xFF, remainder=0, ovf=0. Then dividend=0xFF00, divisor=0xFF -> ovf=1, quotient=0xFF, out_valid 1 cycle after accept.
- Divide by zero: dividend=0x1234, divisor=0 -> div_zero=1, quotient=0xFF, remainder=0x34, latency 1.
- Backpressure: out_ready held low 5 cycles after out_valid -> outputs unchanged, in_ready=0, a new in_valid is ignored. Raising out_ready retires the result, and in_ready returns the next cycle.
- Reset mid-RUN: assert rst on the 4th RUN cycle of 200/7 -> all outputs at reset values that cycle. A following 100/3 gives quotient=33, remainder=1.
- Approx, APPROX_DROP=2: dividend=1000, divisor=9 -> quotient=108 (0x6C), remainder=0, out_valid 7 cycles after accept.
